// File: rtl/jk_reg_bank_if.sv
// rtl/jk_reg_bank_if.sv - Signal bundle between a controller and jk_reg_bank.
// Ports ld and d exist only when JK_LOAD_EN is defined.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             ser_in;
`ifdef JK_LOAD_EN
  logic             ld;
  logic [WIDTH-1:0] d;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             ovf;

  modport master (
`ifdef JK_LOAD_EN
    output ld, d,
`endif
    output en, mode, j, k, ser_in,
    input  q, qb, tc, ovf
  );

  modport slave (
`ifdef JK_LOAD_EN
    input  ld, d,
`endif
    input  en, mode, j, k, ser_in,
    output q, qb, tc, ovf
  );
endinterface

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - WIDTH JK stages run as a JK bank, up/down counter or shift register.
// Define JK_LOAD_EN to add a parallel load (ld/d) that ranks below clear.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          cl,
  jk_reg_bank_if.slave bus
);
  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] j_eff, k_eff;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             tc;

  // Stage i toggles when every lower stage is 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign up_t[i] = &q_q[i-1:0];
    assign dn_t[i] = ~(|q_q[i-1:0]);
  end

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (bus.en) begin
      case (bus.mode)
        MODE_JK: begin
          j_eff = bus.j;
          k_eff = bus.k;
        end
        MODE_UP: begin
          j_eff = up_t;
          k_eff = up_t;
        end
        MODE_DN: begin
          j_eff = dn_t;
          k_eff = dn_t;
        end
        default: begin
          j_eff = {q_q[WIDTH-2:0], bus.ser_in};
          k_eff = ~{q_q[WIDTH-2:0], bus.ser_in};
        end
      endcase
    end
  end

  assign tc = bus.en & (((bus.mode == MODE_UP) & (&q_q)) |
                        ((bus.mode == MODE_DN) & ~(|q_q)));

  always_comb begin
    q_d   = (j_eff & ~q_q) | (~k_eff & q_q);
    ovf_d = tc;
`ifdef JK_LOAD_EN
    if (bus.ld) begin
      q_d   = bus.d;
      ovf_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      q_q   <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.qb  = ~q_q;
  assign bus.tc  = tc;
  assign bus.ovf = ovf_q;
endmodule
